// File: rtl/mem_access_unit_pkg.sv
// Shared CPU encodings: ALU opcodes, memory access type/size, and the
// load-extension convention, plus small decode helpers for the memory path.
package mem_access_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_NOOP = 2'd0,
        MEM_LOAD = 2'd1,
        MEM_STOR = 2'd2
    } mem_type_e;

    typedef enum logic [2:0] {
        SIZE_FULL = 3'd0,
        SIZE_BYTE = 3'd1,
        SIZE_HALF = 3'd2
    } mem_size_e;

    // Value of unsigned_flag selecting each load extension.
    localparam logic EXT_SIGN = 1'b0;
    localparam logic EXT_ZERO = 1'b1;

    function automatic mem_type_e decode_type(input logic [1:0] raw);
        case (raw)
            2'd1:    return MEM_LOAD;
            2'd2:    return MEM_STOR;
            default: return MEM_NOOP;
        endcase
    endfunction

    function automatic mem_size_e decode_size(input logic [2:0] raw);
        case (raw)
            3'd1:    return SIZE_BYTE;
            3'd2:    return SIZE_HALF;
            default: return SIZE_FULL;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lane);
        case (size)
            SIZE_HALF: return lane[0];
            SIZE_FULL: return lane != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input mem_size_e size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: return 4'b0001 << lane;
            SIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    // Narrow stores are replicated so every enabled lane carries the data.
    function automatic logic [31:0] store_data(input mem_size_e size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed lane of a little-endian bus word and extends it to
// 32 bits according to the access size and unsigned_flag.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  mem_size_e   size,
    input  logic        unsigned_flag,
    output logic [31:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic        zero_ext;

    assign zero_ext = (unsigned_flag == EXT_ZERO);
    assign half_val = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        byte_val = rdata[7:0];
        data     = rdata;
        case (lane)
            2'd1:    byte_val = rdata[15:8];
            2'd2:    byte_val = rdata[23:16];
            2'd3:    byte_val = rdata[31:24];
            default: byte_val = rdata[7:0];
        endcase
        case (size)
            SIZE_BYTE: data = {{24{~zero_ext & byte_val[7]}}, byte_val};
            SIZE_HALF: data = {{16{~zero_ext & half_val[15]}}, half_val};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: aligns requests onto a word bus with
// byte enables, returns extended load data, and reports misaligned accesses.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  mem_type,
    input  logic [2:0]  mem_size,
    input  logic        unsigned_flag,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  wb_dest_in,
    input  logic        wb_en_in,
    input  logic        flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_wb_dest,
    output logic        rsp_wb_en,
    output logic        addr_err,
    output logic        addr_err_store,
    output logic [31:0] bad_vaddr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state;

    mem_type_e   type_q;
    mem_size_e   size_q;
    logic [1:0]  lane_q;
    logic        unsigned_q;
    logic [4:0]  wb_dest_q;
    logic        wb_en_q;

    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic [4:0]  rsp_wb_dest_q;
    logic        rsp_wb_en_q;
    logic        addr_err_q;
    logic        addr_err_store_q;
    logic [31:0] bad_vaddr_q;

    mem_type_e   req_type;
    mem_size_e   req_size;
    logic        req_mis;
    logic [31:0] load_data;

    assign req_type = decode_type(mem_type);
    assign req_size = decode_size(mem_size);
    assign req_mis  = (req_type != MEM_NOOP) && is_misaligned(req_size, addr[1:0]);

    load_extend u_load_extend (
        .rdata         (bus_rdata),
        .lane          (lane_q),
        .size          (size_q),
        .unsigned_flag (unsigned_q),
        .data          (load_data)
    );

    assign req_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state            <= ST_IDLE;
            type_q           <= MEM_NOOP;
            size_q           <= SIZE_FULL;
            lane_q           <= '0;
            unsigned_q       <= 1'b0;
            wb_dest_q        <= '0;
            wb_en_q          <= 1'b0;
            bus_req          <= 1'b0;
            bus_we           <= 1'b0;
            bus_be           <= '0;
            bus_addr         <= '0;
            bus_wdata        <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_data_q       <= '0;
            rsp_wb_dest_q    <= '0;
            rsp_wb_en_q      <= 1'b0;
            addr_err_q       <= 1'b0;
            addr_err_store_q <= 1'b0;
            bad_vaddr_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && !flush) begin
                        type_q     <= req_type;
                        size_q     <= req_size;
                        lane_q     <= addr[1:0];
                        unsigned_q <= unsigned_flag;
                        wb_dest_q  <= wb_dest_in;
                        wb_en_q    <= wb_en_in;
                        if (req_type == MEM_NOOP || req_mis) begin
                            state            <= ST_RESP;
                            rsp_valid_q      <= 1'b1;
                            rsp_data_q       <= '0;
                            rsp_wb_dest_q    <= wb_dest_in;
                            rsp_wb_en_q      <= wb_en_in && !req_mis;
                            addr_err_q       <= req_mis;
                            addr_err_store_q <= req_mis && (req_type == MEM_STOR);
                            bad_vaddr_q      <= req_mis ? addr : '0;
                        end else begin
                            state     <= ST_BUS;
                            bus_req   <= 1'b1;
                            bus_we    <= (req_type == MEM_STOR);
                            bus_be    <= byte_enable(req_size, addr[1:0]);
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wdata <= (req_type == MEM_STOR) ? store_data(req_size, wdata) : '0;
                        end
                    end
                end

                ST_BUS: begin
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_be    <= '0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        if (flush) begin
                            state <= ST_IDLE;
                        end else begin
                            state         <= ST_RESP;
                            rsp_valid_q   <= 1'b1;
                            rsp_data_q    <= (type_q == MEM_LOAD) ? load_data : '0;
                            rsp_wb_dest_q <= wb_dest_q;
                            rsp_wb_en_q   <= (type_q == MEM_LOAD) && wb_en_q;
                        end
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end

                // The slave still owes an ack; keep the request up but drop the result.
                ST_DRAIN: begin
                    if (bus_ack) begin
                        state     <= ST_IDLE;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_be    <= '0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                    end
                end

                ST_RESP: begin
                    state            <= ST_IDLE;
                    rsp_valid_q      <= 1'b0;
                    rsp_data_q       <= '0;
                    rsp_wb_dest_q    <= '0;
                    rsp_wb_en_q      <= 1'b0;
                    addr_err_q       <= 1'b0;
                    addr_err_store_q <= 1'b0;
                    bad_vaddr_q      <= '0;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // A flush arriving while the response is being presented cancels it.
    assign rsp_valid      = rsp_valid_q && !flush;
    assign rsp_data       = flush ? '0 : rsp_data_q;
    assign rsp_wb_dest    = flush ? '0 : rsp_wb_dest_q;
    assign rsp_wb_en      = rsp_wb_en_q && !flush;
    assign addr_err       = addr_err_q && !flush;
    assign addr_err_store = addr_err_store_q && !flush;
    assign bad_vaddr      = flush ? '0 : bad_vaddr_q;

endmodule
